pc_sequencer: RTL and testbench

- Owns the W-bit program-counter register. Sequences the load/increment next-value datapath every cycle.
- Arbitrates two load requesters: interrupt vector (high priority) and branch target (low priority).
- Also handles start/stop, pipeline stall, one-cycle post-load bubble and wrap-around halt.
- Sits between the fetch stage (consumes pc_o/fetch_valid_o) and the control unit (start, stop, branch, irq).

---
 rtl/pc_seq_pkg.sv | 23 ++
 rtl/pc_next_logic.sv | 46 ++++
 rtl/pc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Purpose  : Shared types and constants for the program-counter sequencer.
//            Holds the sequencer state encoding, the default PC width and
//            the all-ones PC value used to recognise a wrap.
// Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam int PC_W = 8;

    localparam logic [PC_W-1:0] PC_ONES = {PC_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2,
        HALT   = 2'd3
    } pc_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_next_logic.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_logic
// Purpose  : Combinational next-PC datapath. Selects the load value, the
//            incremented PC, or zero, and reports the increment carry-out.
//            Holding the PC is done by the register enable in the parent,
//            not here.
// Ports    : pc_i        - current PC
//            load_i      - select load_val_i (wins over inc_i)
//            load_val_i  - load target address
//            inc_i       - select pc_i + 1 (W-bit modulo)
//            next_pc_o   - selected next PC
//            carry_out_o - carry out of the increment (wrap detection only)
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_logic
    import pc_seq_pkg::*;
#(
    parameter int W = PC_W
) (
    input  logic [W-1:0] pc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] next_pc_o,
    output logic         carry_out_o
);

    // One extra bit so the carry of the increment falls out naturally.
    logic [W:0] w_sum;

    assign w_sum = {1'b0, pc_i} + {{W{1'b0}}, 1'b1};

    always_comb begin
        next_pc_o   = '0;
        carry_out_o = 1'b0;
        if (load_i) begin
            next_pc_o = load_val_i;
        end else if (inc_i) begin
            next_pc_o   = w_sum[W-1:0];
            carry_out_o = w_sum[W];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Owns the program-counter register and sequences it every cycle:
//            start/stop, stall, increment, prioritised loads (interrupt
//            vector over branch target), a one-cycle bubble after every
//            load, and optional halt when the PC wraps from all-ones to 0.
// Ports    : clk, rst        - clock (rising edge), async active-high reset
//            start_i, stop_i - enter RUN / leave RUN for IDLE
//            stall_i         - freeze PC and state, no acks
//            irq_req_i/vec_i - interrupt load request and target
//            br_req_i/addr_i - branch load request and target
//            irq_ack_o       - registered pulse, interrupt load taken
//            br_ack_o        - registered pulse, branch load taken
//            pc_o            - current PC register
//            fetch_valid_o   - pc_o is a valid fetch address this cycle
//            wrap_o          - registered pulse, PC wrapped all-ones -> 0
//            halted_o        - sequencer is in HALT
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int           W            = PC_W,
    parameter logic [W-1:0] RESET_VEC    = '0,
    parameter bit           HALT_ON_WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         stall_i,
    input  logic         irq_req_i,
    input  logic [W-1:0] irq_vec_i,
    input  logic         br_req_i,
    input  logic [W-1:0] br_addr_i,
    output logic         irq_ack_o,
    output logic         br_ack_o,
    output logic [W-1:0] pc_o,
    output logic         fetch_valid_o,
    output logic         wrap_o,
    output logic         halted_o
);

    pc_state_e    state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic         irq_ack_q, irq_ack_d;
    logic         br_ack_q, br_ack_d;
    logic         wrap_q, wrap_d;

    logic         w_load;
    logic         w_inc;
    logic         w_pc_en;
    logic [W-1:0] w_load_val;
    logic [W-1:0] w_next_pc;
    logic         w_carry;

    pc_next_logic #(
        .W (W)
    ) u_next (
        .pc_i        (pc_q),
        .load_i      (w_load),
        .load_val_i  (w_load_val),
        .inc_i       (w_inc),
        .next_pc_o   (w_next_pc),
        .carry_out_o (w_carry)
    );

    // Next-state, datapath control and registered-pulse computation.
    // Stall suppresses everything, so the whole decision is gated by it.
    always_comb begin
        state_d    = state_q;
        w_load     = 1'b0;
        w_inc      = 1'b0;
        w_pc_en    = 1'b0;
        w_load_val = irq_vec_i;
        irq_ack_d  = 1'b0;
        br_ack_d   = 1'b0;
        wrap_d     = 1'b0;

        if (!stall_i) begin
            unique case (state_q)
                IDLE: begin
                    // Requests stay pending; only start moves us on.
                    if (start_i) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        state_d = IDLE;
                    end else if (irq_req_i) begin
                        w_load     = 1'b1;
                        w_load_val = irq_vec_i;
                        w_pc_en    = 1'b1;
                        irq_ack_d  = 1'b1;
                        state_d    = BUBBLE;
                    end else if (br_req_i) begin
                        w_load     = 1'b1;
                        w_load_val = br_addr_i;
                        w_pc_en    = 1'b1;
                        br_ack_d   = 1'b1;
                        state_d    = BUBBLE;
                    end else begin
                        w_inc   = 1'b1;
                        w_pc_en = 1'b1;
                        // Carry out of the increment means pc was all-ones.
                        if (w_carry) begin
                            wrap_d = 1'b1;
                            if (HALT_ON_WRAP) begin
                                state_d = HALT;
                            end
                        end
                    end
                end
                BUBBLE: begin
                    state_d = RUN;
                end
                HALT: begin
                    // Interrupt beats start; branches are not served here.
                    if (irq_req_i) begin
                        w_load     = 1'b1;
                        w_load_val = irq_vec_i;
                        w_pc_en    = 1'b1;
                        irq_ack_d  = 1'b1;
                        state_d    = BUBBLE;
                    end else if (start_i) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        pc_d = w_pc_en ? w_next_pc : pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_VEC;
            irq_ack_q <= 1'b0;
            br_ack_q  <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            irq_ack_q <= irq_ack_d;
            br_ack_q  <= br_ack_d;
            wrap_q    <= wrap_d;
        end
    end

    assign pc_o          = pc_q;
    assign irq_ack_o     = irq_ack_q;
    assign br_ack_o      = br_ack_q;
    assign wrap_o        = wrap_q;
    assign halted_o      = (state_q == HALT);
    assign fetch_valid_o = (state_q == RUN) && !stall_i;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer. Two instances share the
//            inputs: index 0 halts on wrap, index 1 keeps running. A
//            behavioural model per instance is compared every cycle, and a
//            directed walk through the main scenarios pins literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_BUBBLE = 2;
    localparam int M_HALT   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       stall_i = 1'b0;
    logic       irq_req_i = 1'b0;
    logic [7:0] irq_vec_i = 8'h00;
    logic       br_req_i = 1'b0;
    logic [7:0] br_addr_i = 8'h00;

    logic       irq_ack_o     [2];
    logic       br_ack_o      [2];
    logic [7:0] pc_o          [2];
    logic       fetch_valid_o [2];
    logic       wrap_o        [2];
    logic       halted_o      [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Behavioural model state per instance.
    int m_mode [2];
    int m_pc   [2];
    int m_ia   [2];
    int m_ba   [2];
    int m_wr   [2];
    bit how    [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    pc_sequencer #(.W(8), .RESET_VEC(8'h00), .HALT_ON_WRAP(1'b1)) dut_halt (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .stall_i       (stall_i),
        .irq_req_i     (irq_req_i),
        .irq_vec_i     (irq_vec_i),
        .br_req_i      (br_req_i),
        .br_addr_i     (br_addr_i),
        .irq_ack_o     (irq_ack_o[0]),
        .br_ack_o      (br_ack_o[0]),
        .pc_o          (pc_o[0]),
        .fetch_valid_o (fetch_valid_o[0]),
        .wrap_o        (wrap_o[0]),
        .halted_o      (halted_o[0])
    );

    pc_sequencer #(.W(8), .RESET_VEC(8'h00), .HALT_ON_WRAP(1'b0)) dut_run (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .stall_i       (stall_i),
        .irq_req_i     (irq_req_i),
        .irq_vec_i     (irq_vec_i),
        .br_req_i      (br_req_i),
        .br_addr_i     (br_addr_i),
        .irq_ack_o     (irq_ack_o[1]),
        .br_ack_o      (br_ack_o[1]),
        .pc_o          (pc_o[1]),
        .fetch_valid_o (fetch_valid_o[1]),
        .wrap_o        (wrap_o[1]),
        .halted_o      (halted_o[1])
    );

    task automatic chk(input string name, input int k, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%0h exp=%0h", name, k, $time, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Model: one step of the sequencer rules per rising edge.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_mode[k] = M_IDLE;
                m_pc[k]   = 0;
                m_ia[k]   = 0;
                m_ba[k]   = 0;
                m_wr[k]   = 0;
            end else begin
                m_ia[k] = 0;
                m_ba[k] = 0;
                m_wr[k] = 0;
                if (!stall_i) begin
                    if (m_mode[k] == M_IDLE) begin
                        if (start_i) m_mode[k] = M_RUN;
                    end else if (m_mode[k] == M_BUBBLE) begin
                        m_mode[k] = M_RUN;
                    end else if (m_mode[k] == M_RUN && stop_i) begin
                        m_mode[k] = M_IDLE;
                    end else if (irq_req_i) begin
                        m_pc[k]   = int'(irq_vec_i);
                        m_ia[k]   = 1;
                        m_mode[k] = M_BUBBLE;
                    end else if (m_mode[k] == M_HALT) begin
                        if (start_i) m_mode[k] = M_RUN;
                    end else if (br_req_i) begin
                        m_pc[k]   = int'(br_addr_i);
                        m_ba[k]   = 1;
                        m_mode[k] = M_BUBBLE;
                    end else begin
                        m_pc[k] = (m_pc[k] + 1) % 256;
                        if (m_pc[k] == 0) begin
                            m_wr[k] = 1;
                            if (how[k]) m_mode[k] = M_HALT;
                        end
                    end
                end
            end
        end
    end

    // Compare process: all outputs of both instances on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("m_pc",     k, int'(pc_o[k]),          m_pc[k]);
                chk("m_irqack", k, int'(irq_ack_o[k]),     m_ia[k]);
                chk("m_brack",  k, int'(br_ack_o[k]),      m_ba[k]);
                chk("m_wrap",   k, int'(wrap_o[k]),        m_wr[k]);
                chk("m_halted", k, int'(halted_o[k]),      int'(m_mode[k] == M_HALT));
                chk("m_fvalid", k, int'(fetch_valid_o[k]), int'(m_mode[k] == M_RUN && !stall_i));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Literal check on both instances (they agree outside the wrap window).
    task automatic lit(input string name, input int pc, input int fv, input int ia, input int ba);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk({name, "_pc"}, k, int'(pc_o[k]), pc);
            chk({name, "_fv"}, k, int'(fetch_valid_o[k]), fv);
            chk({name, "_ia"}, k, int'(irq_ack_o[k]), ia);
            chk({name, "_ba"}, k, int'(br_ack_o[k]), ba);
        end
    endtask

    task automatic do_branch(input logic [7:0] addr);
        br_req_i  = 1'b1;
        br_addr_i = addr;
        tick();
        br_req_i  = 1'b0;
        tick();
    endtask

    int t_irq;
    int t_br;

    initial begin
        // ---------------- reset and count ----------------
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        lit("rst", 8'h00, 0, 0, 0);
        chk("rst_halted", 0, int'(halted_o[0]), 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        lit("cnt0", 8'h00, 1, 0, 0);
        tick(); lit("cnt1", 8'h01, 1, 0, 0);
        tick(); lit("cnt2", 8'h02, 1, 0, 0);
        tick(); lit("cnt3", 8'h03, 1, 0, 0);
        for (int i = 0; i < 8'h34; i++) tick();
        lit("cnt37", 8'h37, 1, 0, 0);
        rst = 1'b1;
        lit("async_rst", 8'h00, 0, 0, 0);
        tick();
        rst = 1'b0;

        // ---------------- branch load ----------------
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        lit("pre_br", 8'h10, 1, 0, 0);
        br_req_i  = 1'b1;
        br_addr_i = 8'hA0;
        tick();
        br_req_i = 1'b0;
        lit("br_load", 8'hA0, 0, 0, 1);
        tick(); lit("br_run", 8'hA0, 1, 0, 0);
        tick(); lit("br_inc", 8'hA1, 1, 0, 0);

        // ---------------- simultaneous requests ----------------
        irq_req_i = 1'b1;
        irq_vec_i = 8'hF0;
        br_req_i  = 1'b1;
        br_addr_i = 8'h40;
        tick();
        irq_req_i = 1'b0;
        t_irq = cyc;
        lit("sim_irq", 8'hF0, 0, 1, 0);
        tick(); lit("sim_bub", 8'hF0, 1, 0, 0);
        tick();
        br_req_i = 1'b0;
        t_br = cyc;
        lit("sim_br", 8'h40, 0, 0, 1);
        chk("ack_gap", 0, t_br - t_irq, 2);
        tick(); lit("sim_run", 8'h40, 1, 0, 0);

        // ---------------- wrap ----------------
        do_branch(8'hFE);
        lit("wr_fe", 8'hFE, 1, 0, 0);
        tick(); lit("wr_ff", 8'hFF, 1, 0, 0);
        tick();
        #1;
        chk("wr_pc",     0, int'(pc_o[0]), 8'h00);
        chk("wr_pulse",  0, int'(wrap_o[0]), 1);
        chk("wr_halted", 0, int'(halted_o[0]), 1);
        chk("wr_pc",     1, int'(pc_o[1]), 8'h00);
        chk("wr_pulse",  1, int'(wrap_o[1]), 1);
        chk("wr_halted", 1, int'(halted_o[1]), 0);
        tick();
        #1;
        chk("hlt_pc",    0, int'(pc_o[0]), 8'h00);
        chk("hlt_fv",    0, int'(fetch_valid_o[0]), 0);
        chk("hlt_wrap",  0, int'(wrap_o[0]), 0);
        chk("nw_pc",     1, int'(pc_o[1]), 8'h01);
        irq_req_i = 1'b1;
        irq_vec_i = 8'h20;
        tick();
        irq_req_i = 1'b0;
        lit("hlt_irq", 8'h20, 0, 1, 0);
        chk("hlt_clr", 0, int'(halted_o[0]), 0);
        tick(); lit("hlt_run", 8'h20, 1, 0, 0);
        tick(); lit("hlt_inc", 8'h21, 1, 0, 0);

        // ---------------- stall ----------------
        do_branch(8'h05);
        lit("st_pre", 8'h05, 1, 0, 0);
        br_req_i  = 1'b1;
        br_addr_i = 8'h77;
        stall_i   = 1'b1;
        stop_i    = 1'b1;
        tick();
        stop_i = 1'b0;
        lit("st_1", 8'h05, 0, 0, 0);
        tick(); lit("st_2", 8'h05, 0, 0, 0);
        tick(); lit("st_3", 8'h05, 0, 0, 0);
        stall_i = 1'b0;
        lit("st_rel", 8'h05, 1, 0, 0);
        tick();
        br_req_i = 1'b0;
        lit("st_br", 8'h77, 0, 0, 1);
        tick();

        // ---------------- idle / stop ----------------
        do_branch(8'h09);
        stop_i = 1'b1;
        tick();
        stop_i    = 1'b0;
        br_req_i  = 1'b1;
        br_addr_i = 8'h55;
        lit("idle", 8'h09, 0, 0, 0);
        tick(); lit("idle_1", 8'h09, 0, 0, 0);
        tick(); lit("idle_2", 8'h09, 0, 0, 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        lit("idle_go", 8'h09, 1, 0, 0);
        tick();
        br_req_i = 1'b0;
        lit("idle_br", 8'h55, 0, 0, 1);

        // ---------------- randomised traffic ----------------
        for (int n = 0; n < 4000; n++) begin
            tick();
            if (irq_ack_o[0]) irq_req_i = 1'b0;
            if (br_ack_o[0])  br_req_i  = 1'b0;
            start_i = ($urandom_range(0, 99) < 8);
            stop_i  = ($urandom_range(0, 99) < 3);
            stall_i = ($urandom_range(0, 99) < 15);
            if (!irq_req_i) begin
                if ($urandom_range(0, 99) < 4) begin
                    irq_req_i = 1'b1;
                    irq_vec_i = 8'($urandom_range(0, 255));
                end
            end else if ($urandom_range(0, 99) < 3) begin
                irq_req_i = 1'b0;
            end
            if (!br_req_i) begin
                if ($urandom_range(0, 99) < 10) begin
                    br_req_i  = 1'b1;
                    br_addr_i = ($urandom_range(0, 99) < 40) ? 8'($urandom_range(248, 255))
                                                              : 8'($urandom_range(0, 255));
                end
            end else if ($urandom_range(0, 99) < 3) begin
                br_req_i = 1'b0;
            end
            if ($urandom_range(0, 999) < 4) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
        end

        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
